bpu_lvl_2: RTL and testbench

Second-generation branch prediction unit for the core's fetch stage. It replaces the fixed-geometry level-1 predictor with a parametrised gshare predictor. The predictor holds a pattern history table (PHT) of 2-bit saturating counters, indexed by the instruction pointer XOR a global history register (GHR). It returns a registered taken/not-taken prediction with a history snapshot, accepts resolved-branch updates from execute, and restores history on a mispredict. After reset it runs a self-clearing initialisation sequence.

---
 rtl/bpu_lvl_2_pkg.sv | 30 +++
 rtl/bpu_lvl_2_if.sv | 41 ++++
 rtl/bpu_lvl_2_pht.sv | 53 +++++
 rtl/bpu_lvl_2.sv | 122 ++++++++++++
 tb/tb_bpu_lvl_2.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/bpu_lvl_2_pkg.sv
// Shared types and helpers for the bpu_lvl_2 gshare predictor.
// Optional statistics counters are enabled by defining BPU_LVL_2_STATS_EN.
package bpu_pkg;

  typedef logic [1:0] pht_cnt_t;

  localparam pht_cnt_t CNT_SNT = 2'b00;
  localparam pht_cnt_t CNT_WNT = 2'b01;
  localparam pht_cnt_t CNT_WT  = 2'b10;
  localparam pht_cnt_t CNT_ST  = 2'b11;

  typedef enum logic [0:0] {
    BPU_INIT = 1'b0,
    BPU_RUN  = 1'b1
  } bpu_state_t;

  // Saturating 2-bit counter step: towards CNT_ST on taken, towards CNT_SNT otherwise.
  function automatic pht_cnt_t sat_update(input pht_cnt_t cnt, input logic taken);
    pht_cnt_t nxt;
    if (taken) begin
      if (cnt == CNT_ST) nxt = CNT_ST;
      else               nxt = cnt + 2'd1;
    end else begin
      if (cnt == CNT_SNT) nxt = CNT_SNT;
      else                nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_lvl_2_if.sv
// Fetch/execute-facing bus of the bpu_lvl_2 predictor.
// Statistics signals exist only when BPU_LVL_2_STATS_EN is defined.
interface bpu_lvl_2_if #(
  parameter int IP_WIDTH   = 8,
  parameter int HIST_WIDTH = 4
);
  logic                  ready_o;
  logic                  pred_req_i;
  logic [IP_WIDTH-1:0]   pred_ip_i;
  logic                  pred_valid_o;
  logic                  pred_taken_o;
  logic [HIST_WIDTH-1:0] pred_hist_o;
  logic                  upd_valid_i;
  logic [IP_WIDTH-1:0]   upd_ip_i;
  logic [HIST_WIDTH-1:0] upd_hist_i;
  logic                  upd_taken_i;
  logic                  upd_mispredict_i;
`ifdef BPU_LVL_2_STATS_EN
  logic [31:0]           stat_pred_o;
  logic [31:0]           stat_miss_o;
`endif

  modport master (
    input  ready_o, pred_valid_o, pred_taken_o, pred_hist_o,
    output pred_req_i, pred_ip_i, upd_valid_i, upd_ip_i, upd_hist_i,
           upd_taken_i, upd_mispredict_i
`ifdef BPU_LVL_2_STATS_EN
    , input stat_pred_o, stat_miss_o
`endif
  );

  modport slave (
    output ready_o, pred_valid_o, pred_taken_o, pred_hist_o,
    input  pred_req_i, pred_ip_i, upd_valid_i, upd_ip_i, upd_hist_i,
           upd_taken_i, upd_mispredict_i
`ifdef BPU_LVL_2_STATS_EN
    , output stat_pred_o, stat_miss_o
`endif
  );

endinterface

// File: rtl/bpu_lvl_2_pht.sv
// Pattern history table: DEPTH x 2-bit counters, combinational lookup port
// (sampled by the caller's output register) and one muxed write port.
module bpu_pht
  import bpu_pkg::*;
#(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   clr_en,
  input  logic [INDEX_WIDTH-1:0] clr_idx,
  input  logic                   upd_en,
  input  logic [INDEX_WIDTH-1:0] upd_idx,
  input  logic                   upd_taken,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output pht_cnt_t               rd_cnt
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;

  pht_cnt_t               mem_r [DEPTH];
  logic                   wr_en_s;
  logic [INDEX_WIDTH-1:0] wr_idx_s;
  pht_cnt_t               wr_cnt_s;

  // Lookup sees the pre-edge contents, so a same-cycle write yields read-old data.
  assign rd_cnt = mem_r[rd_idx];

  // Write-port mux: clear sweep during init, saturating update during run.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = upd_idx;
    wr_cnt_s = CNT_WNT;
    if (clr_en) begin
      wr_en_s  = 1'b1;
      wr_idx_s = clr_idx;
      wr_cnt_s = CNT_WNT;
    end else if (upd_en) begin
      wr_en_s  = 1'b1;
      wr_idx_s = upd_idx;
      wr_cnt_s = sat_update(mem_r[upd_idx], upd_taken);
    end else begin
      wr_en_s  = 1'b0;
    end
  end

  // Table storage; contents are defined by the init sweep, not by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= wr_cnt_s;
    end
  end

endmodule

// File: rtl/bpu_lvl_2.sv
// bpu_lvl_2: gshare branch predictor with self-clearing init sweep.
// Define BPU_LVL_2_STATS_EN to add saturating prediction/mispredict counters.
module bpu_lvl_2
  import bpu_pkg::*;
#(
  parameter int IP_WIDTH    = 8,
  parameter int INDEX_WIDTH = 6,
  parameter int HIST_WIDTH  = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  bpu_lvl_2_if.slave bus
);

  localparam logic [0:0] ST_INIT = 1'(BPU_INIT);
  localparam logic [0:0] ST_RUN  = 1'(BPU_RUN);

  logic [0:0]             state_r;
  logic [INDEX_WIDTH-1:0] clr_ptr_r;
  logic [HIST_WIDTH-1:0]  ghr_r;
  logic                   pred_valid_r;
  logic                   pred_taken_r;
  logic [HIST_WIDTH-1:0]  pred_hist_r;

  logic                   run_s;
  logic                   mispredict_s;
  logic                   accept_s;
  logic [INDEX_WIDTH-1:0] rd_idx_s;
  logic [INDEX_WIDTH-1:0] upd_idx_s;
  pht_cnt_t               rd_cnt_s;
  logic [HIST_WIDTH:0]    ghr_shift_s;
  logic [HIST_WIDTH:0]    ghr_restore_s;
  logic [HIST_WIDTH-1:0]  ghr_nxt_s;
  logic                   unused_ip_s;

  assign run_s        = (state_r == ST_RUN);
  assign mispredict_s = run_s & bus.upd_valid_i & bus.upd_mispredict_i;
  assign accept_s     = run_s & bus.pred_req_i & ~mispredict_s;
  assign rd_idx_s     = bus.pred_ip_i[INDEX_WIDTH-1:0] ^ INDEX_WIDTH'(ghr_r);
  assign upd_idx_s    = bus.upd_ip_i[INDEX_WIDTH-1:0] ^ INDEX_WIDTH'(bus.upd_hist_i);
  // Upper IP bits and the counter LSB do not influence the prediction.
  assign unused_ip_s  = &{1'b0, bus.pred_ip_i, bus.upd_ip_i, rd_cnt_s[0]};

  // Concatenate then keep the low bits so HIST_WIDTH=1 needs no special case.
  assign ghr_shift_s   = {ghr_r, rd_cnt_s[1]};
  assign ghr_restore_s = {bus.upd_hist_i, bus.upd_taken_i};

  // Next history: mispredict recovery outranks speculative shift-in.
  always_comb begin
    ghr_nxt_s = ghr_r;
    if (mispredict_s) begin
      ghr_nxt_s = ghr_restore_s[HIST_WIDTH-1:0];
    end else if (accept_s) begin
      ghr_nxt_s = ghr_shift_s[HIST_WIDTH-1:0];
    end else begin
      ghr_nxt_s = ghr_r;
    end
  end

  bpu_pht #(.INDEX_WIDTH(INDEX_WIDTH)) u_pht (
    .clk       (clk_i),
    .clr_en    (~run_s & ~rst_i),
    .clr_idx   (clr_ptr_r),
    .upd_en    (run_s & bus.upd_valid_i & ~rst_i),
    .upd_idx   (upd_idx_s),
    .upd_taken (bus.upd_taken_i),
    .rd_idx    (rd_idx_s),
    .rd_cnt    (rd_cnt_s)
  );

  // Init/run sequencing, global history and the registered prediction outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_INIT;
      clr_ptr_r    <= '0;
      ghr_r        <= '0;
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
      pred_hist_r  <= '0;
    end else begin
      case (state_r)
        ST_INIT: begin
          clr_ptr_r <= clr_ptr_r + INDEX_WIDTH'(1'b1);
          if (&clr_ptr_r) state_r <= ST_RUN;
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_INIT;
      endcase
      ghr_r        <= ghr_nxt_s;
      pred_valid_r <= accept_s;
      if (accept_s) begin
        pred_taken_r <= rd_cnt_s[1];
        pred_hist_r  <= ghr_r;
      end
    end
  end

  assign bus.ready_o      = run_s;
  assign bus.pred_valid_o = pred_valid_r;
  assign bus.pred_taken_o = pred_taken_r;
  assign bus.pred_hist_o  = pred_hist_r;

`ifdef BPU_LVL_2_STATS_EN
  logic [31:0] stat_pred_r;
  logic [31:0] stat_miss_r;

  // Saturating event counters; inputs are ignored outside RUN via accept/mispredict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_pred_r <= 32'd0;
      stat_miss_r <= 32'd0;
    end else begin
      if (accept_s && (stat_pred_r != 32'hFFFF_FFFF)) stat_pred_r <= stat_pred_r + 32'd1;
      if (mispredict_s && (stat_miss_r != 32'hFFFF_FFFF)) stat_miss_r <= stat_miss_r + 32'd1;
    end
  end

  assign bus.stat_pred_o = stat_pred_r;
  assign bus.stat_miss_o = stat_miss_r;
`endif

endmodule

// File: tb/tb_bpu_lvl_2.sv
// Self-checking bench for bpu_lvl_2 (INDEX_WIDTH=4, HIST_WIDTH=4): directed
// scenarios followed by random traffic against a behavioural gshare model.
module tb_bpu_lvl_2;

  localparam int IPW   = 8;
  localparam int IW    = 4;
  localparam int HW    = 4;
  localparam int DEPTH = 16;
  localparam int HMOD  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpu_lvl_2_if #(.IP_WIDTH(IPW), .HIST_WIDTH(HW)) bus ();

  bpu_lvl_2 #(.IP_WIDTH(IPW), .INDEX_WIDTH(IW), .HIST_WIDTH(HW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int     total = 0;
  int     bad   = 0;
  int     m_pht [DEPTH];
  int     m_ghr = 0;
  bit     m_run = 1'b0;
  int     m_clr = 0;
  longint m_sp  = 0;
  longint m_sm  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit req, input int ip, input bit uv, input int uip,
                       input int uh, input bit ut, input bit um);
    bus.pred_req_i       = req;
    bus.pred_ip_i        = IPW'(ip);
    bus.upd_valid_i      = uv;
    bus.upd_ip_i         = IPW'(uip);
    bus.upd_hist_i       = HW'(uh);
    bus.upd_taken_i      = ut;
    bus.upd_mispredict_i = um;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // One clock: advance the model with the driven inputs, then compare after the edge.
  task automatic tick();
    bit misp, acc, e_valid, e_chk;
    int idx, ui, e_taken, e_hist;
    e_valid = 1'b0; e_chk = 1'b0; e_taken = 0; e_hist = 0;
    if (rst) begin
      m_run = 1'b0; m_clr = 0; m_ghr = 0; m_sp = 0; m_sm = 0; e_chk = 1'b1;
    end else if (!m_run) begin
      m_clr++;
      if (m_clr == DEPTH) begin
        m_run = 1'b1;
        foreach (m_pht[i]) m_pht[i] = 1;
      end
    end else begin
      misp = bus.upd_valid_i && bus.upd_mispredict_i;
      acc  = bus.pred_req_i && !misp;
      if (acc) begin
        idx     = (int'(bus.pred_ip_i) % DEPTH) ^ m_ghr;
        e_valid = 1'b1; e_chk = 1'b1;
        e_taken = (m_pht[idx] >= 2) ? 1 : 0;
        e_hist  = m_ghr;
        m_ghr   = (m_ghr * 2 + e_taken) % HMOD;
        if (m_sp < 64'hFFFF_FFFF) m_sp++;
      end
      if (bus.upd_valid_i) begin
        ui = (int'(bus.upd_ip_i) % DEPTH) ^ int'(bus.upd_hist_i);
        if (bus.upd_taken_i) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
        else                 m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
      end
      if (misp) begin
        m_ghr = (int'(bus.upd_hist_i) * 2 + int'(bus.upd_taken_i)) % HMOD;
        if (m_sm < 64'hFFFF_FFFF) m_sm++;
      end
    end
    @(posedge clk);
    #1;
    check("ready", 32'(bus.ready_o), 32'(m_run));
    check("pred_valid", 32'(bus.pred_valid_o), 32'(e_valid));
    if (e_chk) begin
      check("pred_taken", 32'(bus.pred_taken_o), 32'(e_taken));
      check("pred_hist", 32'(bus.pred_hist_o), 32'(e_hist));
    end
`ifdef BPU_LVL_2_STATS_EN
    check("stat_pred", bus.stat_pred_o, 32'(m_sp));
    check("stat_miss", bus.stat_miss_o, 32'(m_sm));
`endif
  endtask

  initial begin
    int n;
    idle();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_hist", 32'(bus.pred_hist_o), 32'd0);

    // Init sweep length
    rst = 1'b0;
    n = 0;
    while (!bus.ready_o && n < 100) begin tick(); n++; end
    check("init_len", n, 32'd16);

    // First predictions / speculative history with not-taken counters
    repeat (3) begin
      drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
      tick();
      check("spec_taken", 32'(bus.pred_taken_o), 32'd0);
      check("spec_hist", 32'(bus.pred_hist_o), 32'd0);
    end

    // Training on IP 5, history forced to 0 through a mispredict restore
    repeat (2) begin drive(1'b0, 0, 1'b1, 8'h05, 0, 1'b1, 1'b0); tick(); end
    drive(1'b0, 0, 1'b1, 8'h0F, 0, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h05, 1'b0, 0, 0, 1'b0, 1'b0); tick();
    check("train_taken", 32'(bus.pred_taken_o), 32'd1);
    repeat (4) begin drive(1'b0, 0, 1'b1, 8'h05, 0, 1'b1, 1'b0); tick(); end
    drive(1'b0, 0, 1'b1, 8'h05, 0, 1'b0, 1'b0); tick();
    drive(1'b0, 0, 1'b1, 8'h0F, 0, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h05, 1'b0, 0, 0, 1'b0, 1'b0); tick();
    check("train_sat", 32'(bus.pred_taken_o), 32'd1);

    // Mispredict with a simultaneous request drops the request
    drive(1'b1, 8'h11, 1'b1, 8'h20, 4'b0101, 1'b1, 1'b1); tick();
    check("misp_drop", 32'(bus.pred_valid_o), 32'd0);
    drive(1'b1, 8'h11, 1'b0, 0, 0, 1'b0, 1'b0); tick();
    check("misp_hist", 32'(bus.pred_hist_o), 32'hB);

    // Read-old collision on index 3
    drive(1'b0, 0, 1'b1, 8'h0F, 0, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h03, 1'b1, 8'h03, 0, 1'b1, 1'b0); tick();
    check("collide_old", 32'(bus.pred_taken_o), 32'd0);
    drive(1'b1, 8'h03, 1'b0, 0, 0, 1'b0, 1'b0); tick();
    check("collide_new", 32'(bus.pred_taken_o), 32'd1);

    // Reset in the middle of operation
    drive(1'b1, 8'h07, 1'b0, 0, 0, 1'b0, 1'b0); tick();
    check("pre_rst_valid", 32'(bus.pred_valid_o), 32'd1);
    rst = 1'b1; tick();
    check("mid_rst_valid", 32'(bus.pred_valid_o), 32'd0);
    check("mid_rst_taken", 32'(bus.pred_taken_o), 32'd0);
    rst = 1'b0; idle();
    n = 0;
    while (!bus.ready_o && n < 100) begin tick(); n++; end
    check("reinit_len", n, 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, i, 1'b0, 0, 0, 1'b0, 1'b0); tick();
      check("clr_entry", 32'(bus.pred_taken_o), 32'd0);
    end

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 255),
            $urandom_range(0, 2) != 0, $urandom_range(0, 255),
            (c % 2 == 0) ? int'(bus.pred_hist_o) : $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0; idle(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
